// File: rtl/mem_port_arbiter_pkg.sv
// Shared pipeline definitions for the memory port arbiter.
// Holds the arbiter FSM state encoding, the fault-code constants reported
// on a completed transaction, and the width of the response wait counter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } arb_state_e;

    typedef logic [1:0] fault_code_t;

    localparam fault_code_t FAULT_NONE    = 2'd0;
    localparam fault_code_t FAULT_BUS     = 2'd1;
    localparam fault_code_t FAULT_TIMEOUT = 2'd2;

    localparam int unsigned WAIT_CNT_W = 8;

    function automatic logic fault_asserted(input fault_code_t code);
        return (code != FAULT_NONE);
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and data access.
// At most one memory transaction is outstanding. Data requests win ties
// unless fetch has been passed over STARVE_LIMIT times in a row. A fetch
// can be cancelled by if_flush; its response is then consumed silently.
// A transaction with no response after TIMEOUT_CYCLES wait cycles completes
// with an access fault.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   if_addr/if_en/if_flush     fetch request side
//   if_inst/if_valid/if_access_fault   fetch response
//   d_addr/d_wdata/d_en/d_we/d_wstrb   data request side
//   d_rdata/d_valid/d_access_fault     data response
//   mem_req/mem_addr/mem_wdata/mem_we/mem_wstrb   registered memory request
//   mem_rsp_valid/mem_rdata/mem_err               memory response
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_addr,
    input  logic        if_en,
    input  logic        if_flush,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic        if_access_fault,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_en,
    input  logic        d_we,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        d_access_fault,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err
);

    localparam int unsigned STARVE_W =
        ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
    localparam logic [STARVE_W-1:0]   STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX   = WAIT_CNT_W'(TIMEOUT_CYCLES);

    arb_state_e            r_state;
    logic [STARVE_W-1:0]   r_starve_cnt;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic                  r_drop;
    logic                  r_mem_req;
    logic [31:0]           r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic                  r_mem_we;
    logic [3:0]            r_mem_wstrb;

    logic        w_grant_if;
    logic        w_grant_d;
    logic        w_busy;
    logic        w_rsp;
    logic        w_timeout;
    logic        w_done;
    fault_code_t w_fault_code;
    logic        w_fault;
    logic        w_if_valid;
    logic        w_d_valid;

    // Grant/priority: data wins a tie unless fetch has been starved.
    always_comb begin
        w_grant_if = 1'b0;
        w_grant_d  = 1'b0;
        if (r_state == IDLE) begin
            if (d_en && !(if_en && (r_starve_cnt == STARVE_MAX))) begin
                w_grant_d = 1'b1;
            end else if (if_en) begin
                w_grant_if = 1'b1;
            end
        end
    end

    // A real response takes precedence over a timeout in the same cycle.
    assign w_busy    = (r_state != IDLE);
    assign w_rsp     = w_busy & mem_rsp_valid;
    assign w_timeout = w_busy & ~mem_rsp_valid & (r_wait_cnt == WAIT_MAX);
    assign w_done    = w_rsp | w_timeout;

    always_comb begin
        w_fault_code = FAULT_NONE;
        if (w_rsp) begin
            w_fault_code = mem_err ? FAULT_BUS : FAULT_NONE;
        end else if (w_timeout) begin
            w_fault_code = FAULT_TIMEOUT;
        end
    end

    assign w_fault = fault_asserted(w_fault_code);

    // A flush arriving in the completion cycle itself also hides the fetch.
    assign w_if_valid = w_done & (r_state == IF_BUSY) & ~r_drop & ~if_flush;
    assign w_d_valid  = w_done & (r_state == D_BUSY);

    assign if_valid        = w_if_valid;
    assign if_inst         = mem_rdata;
    assign if_access_fault = w_if_valid & w_fault;
    assign d_valid         = w_d_valid;
    assign d_rdata         = mem_rdata;
    assign d_access_fault  = w_d_valid & w_fault;

    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;
    assign mem_wstrb = r_mem_wstrb;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_wait_cnt   <= '0;
            r_drop       <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wstrb  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_drop <= 1'b0;
                    if (w_grant_d) begin
                        r_state     <= D_BUSY;
                        r_mem_req   <= 1'b1;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        r_mem_we    <= d_we;
                        r_mem_wstrb <= d_wstrb;
                        r_wait_cnt  <= '0;
                        if (if_en && (r_starve_cnt != STARVE_MAX)) begin
                            r_starve_cnt <= r_starve_cnt + 1'b1;
                        end
                    end else if (w_grant_if) begin
                        r_state      <= IF_BUSY;
                        r_mem_req    <= 1'b1;
                        r_mem_addr   <= if_addr;
                        r_mem_wdata  <= '0;
                        r_mem_we     <= 1'b0;
                        r_mem_wstrb  <= '0;
                        r_wait_cnt   <= '0;
                        r_starve_cnt <= '0;
                    end
                end
                IF_BUSY, D_BUSY: begin
                    if (w_done) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                        r_drop    <= 1'b0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                        if ((r_state == IF_BUSY) && if_flush) begin
                            r_drop <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by a
// randomized phase checked against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int unsigned LIMIT = 4;
    localparam int unsigned TMO   = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_addr;
    logic        if_en;
    logic        if_flush;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        if_access_fault;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_en;
    logic        d_we;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_access_fault;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        mem_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .STARVE_LIMIT  (LIMIT),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .if_addr        (if_addr),
        .if_en          (if_en),
        .if_flush       (if_flush),
        .if_inst        (if_inst),
        .if_valid       (if_valid),
        .if_access_fault(if_access_fault),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_en           (d_en),
        .d_we           (d_we),
        .d_wstrb        (d_wstrb),
        .d_rdata        (d_rdata),
        .d_valid        (d_valid),
        .d_access_fault (d_access_fault),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_we         (mem_we),
        .mem_wstrb      (mem_wstrb),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rdata      (mem_rdata),
        .mem_err        (mem_err)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // at the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        #4;
    endtask

    task automatic quiet_inputs();
        if_addr = '0; if_en = 1'b0; if_flush = 1'b0;
        d_addr = '0; d_wdata = '0; d_en = 1'b0; d_we = 1'b0; d_wstrb = '0;
        mem_rsp_valid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    endtask

    // Reference model: one outstanding transaction record plus requester state.
    logic        m_out;
    logic        m_fetch;
    int          m_age;
    int          m_lat;
    logic        m_drop;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_we;
    logic [3:0]  m_wstrb;
    int          m_passed_over;
    logic        if_pend;
    logic [31:0] if_a;
    logic        d_pend;
    logic [31:0] d_a;
    logic [31:0] d_wd;
    logic        d_w;
    logic [3:0]  d_s;

    initial begin
        int early;
        logic done;
        logic exp_iv;
        logic exp_dv;
        logic exp_fault;
        logic fetch_wins;

        reset = 1'b0;
        quiet_inputs();
        next_cycle();
        next_cycle();
        sample();
        chk1 ("rst_mem_req",   mem_req, 1'b0);
        chk32("rst_mem_addr",  mem_addr, 32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
        chk32("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
        chk1 ("rst_mem_we",    mem_we, 1'b0);
        chk1 ("rst_if_valid",  if_valid, 1'b0);
        chk1 ("rst_d_valid",   d_valid, 1'b0);

        // Scenario 1: plain fetch, response in the third busy cycle.
        next_cycle();
        reset = 1'b1; if_en = 1'b1; if_addr = 32'h100;
        sample();
        chk1 ("s1_idle_req", mem_req, 1'b0);
        next_cycle();
        sample();
        chk1 ("s1_grant_req", mem_req, 1'b1);
        chk32("s1_addr", mem_addr, 32'h100);
        chk1 ("s1_we", mem_we, 1'b0);
        chk1 ("s1_wait0_iv", if_valid, 1'b0);
        next_cycle();
        sample();
        chk1 ("s1_wait1_iv", if_valid, 1'b0);
        next_cycle();
        mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0013;
        sample();
        chk1 ("s1_iv", if_valid, 1'b1);
        chk32("s1_inst", if_inst, 32'h13);
        chk1 ("s1_fault", if_access_fault, 1'b0);
        chk1 ("s1_dv", d_valid, 1'b0);
        next_cycle();
        if_en = 1'b0; mem_rsp_valid = 1'b0;
        sample();
        chk1 ("s1_idle_after", mem_req, 1'b0);

        // Scenario 2: both requesters held, memory always answering.
        next_cycle();
        d_en = 1'b1; if_en = 1'b1; d_addr = 32'h2000; if_addr = 32'h3000;
        mem_rsp_valid = 1'b1; mem_rdata = 32'h5A5A_0000;
        sample();
        chk1 ("s2_pre_req", mem_req, 1'b0);
        chk1 ("s2_late_dv", d_valid, 1'b0);
        chk1 ("s2_late_iv", if_valid, 1'b0);
        for (int n = 0; n < 10; n++) begin
            next_cycle();
            mem_rdata = 32'hC0DE_0000 | 32'(n);
            sample();
            chk1 ("s2_req", mem_req, 1'b1);
            chk32("s2_addr", mem_addr, ((n % 5) == 4) ? 32'h3000 : 32'h2000);
            chk1 ("s2_iv", if_valid, ((n % 5) == 4));
            chk1 ("s2_dv", d_valid, ((n % 5) != 4));
            next_cycle();
            sample();
            chk1 ("s2_gap_req", mem_req, 1'b0);
            chk1 ("s2_gap_dv", d_valid, 1'b0);
            chk1 ("s2_gap_iv", if_valid, 1'b0);
        end
        d_en = 1'b0; if_en = 1'b0; mem_rsp_valid = 1'b0;

        // Scenario 3: flushed fetch, then normal fetch, then coincident flush.
        next_cycle();
        if_en = 1'b1; if_addr = 32'h400;
        sample();
        chk1 ("s3_idle_req", mem_req, 1'b0);
        next_cycle();
        if_flush = 1'b1; if_en = 1'b0;
        sample();
        chk1 ("s3_req", mem_req, 1'b1);
        chk32("s3_addr", mem_addr, 32'h400);
        chk1 ("s3_iv0", if_valid, 1'b0);
        next_cycle();
        if_flush = 1'b0;
        sample();
        chk1 ("s3_iv1", if_valid, 1'b0);
        next_cycle();
        sample();
        chk1 ("s3_iv2", if_valid, 1'b0);
        next_cycle();
        mem_rsp_valid = 1'b1; mem_rdata = 32'h77;
        sample();
        chk1 ("s3_dropped_iv", if_valid, 1'b0);
        chk1 ("s3_dropped_dv", d_valid, 1'b0);
        next_cycle();
        mem_rsp_valid = 1'b0; if_en = 1'b1; if_addr = 32'h500;
        sample();
        chk1 ("s3_idle2_req", mem_req, 1'b0);
        next_cycle();
        mem_rsp_valid = 1'b1; mem_rdata = 32'h1234;
        sample();
        chk32("s3_next_addr", mem_addr, 32'h500);
        chk1 ("s3_next_iv", if_valid, 1'b1);
        chk32("s3_next_inst", if_inst, 32'h1234);
        next_cycle();
        mem_rsp_valid = 1'b0; if_addr = 32'h600;
        sample();
        chk1 ("s3_idle3_req", mem_req, 1'b0);
        next_cycle();
        mem_rsp_valid = 1'b1; if_flush = 1'b1;
        sample();
        chk32("s3_coinc_addr", mem_addr, 32'h600);
        chk1 ("s3_coinc_iv", if_valid, 1'b0);
        next_cycle();
        mem_rsp_valid = 1'b0; if_flush = 1'b0; if_en = 1'b0;
        sample();
        chk1 ("s3_end_req", mem_req, 1'b0);

        // Scenario 4: write to a silent memory times out.
        next_cycle();
        d_en = 1'b1; d_we = 1'b1; d_wstrb = 4'h3; d_addr = 32'h800; d_wdata = 32'hDEAD_BEEF;
        sample();
        chk1 ("s4_idle_req", mem_req, 1'b0);
        next_cycle();
        if_flush = 1'b1;
        sample();
        chk1 ("s4_req", mem_req, 1'b1);
        chk1 ("s4_we", mem_we, 1'b1);
        chk32("s4_wstrb", 32'(mem_wstrb), 32'h3);
        chk32("s4_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk32("s4_addr", mem_addr, 32'h800);
        early = (d_valid || !mem_req) ? 1 : 0;
        for (int k = 1; k < 255; k++) begin
            next_cycle();
            if_flush = 1'b0;
            sample();
            if (d_valid || !mem_req) early++;
        end
        chk32("s4_no_early_end", 32'(early), 32'h0);
        next_cycle();
        sample();
        chk1 ("s4_tmo_dv", d_valid, 1'b1);
        chk1 ("s4_tmo_fault", d_access_fault, 1'b1);
        chk1 ("s4_tmo_req", mem_req, 1'b1);
        next_cycle();
        d_en = 1'b0; d_we = 1'b0; d_wstrb = '0;
        sample();
        chk1 ("s4_after_req", mem_req, 1'b0);
        chk1 ("s4_after_dv", d_valid, 1'b0);

        // Scenario 5: reset in the middle of a data transaction.
        next_cycle();
        d_en = 1'b1; d_addr = 32'h900;
        sample();
        chk1 ("s5_idle_req", mem_req, 1'b0);
        next_cycle();
        #1;
        chk1 ("s5_busy_req", mem_req, 1'b1);
        reset = 1'b0;
        #1;
        chk1 ("s5_async_req", mem_req, 1'b0);
        mem_rsp_valid = 1'b1; mem_rdata = 32'h9999;
        #2;
        chk1 ("s5_rst_dv", d_valid, 1'b0);
        next_cycle();
        reset = 1'b1; d_en = 1'b0;
        sample();
        chk1 ("s5_late_dv", d_valid, 1'b0);
        chk1 ("s5_late_iv", if_valid, 1'b0);
        chk1 ("s5_late_req", mem_req, 1'b0);
        next_cycle();
        mem_rsp_valid = 1'b0;
        sample();
        chk1 ("s5_end_req", mem_req, 1'b0);

        // Scenario 6: bus error on a fetch.
        next_cycle();
        if_en = 1'b1; if_addr = 32'hA00;
        sample();
        chk1 ("s6_idle_req", mem_req, 1'b0);
        next_cycle();
        mem_rsp_valid = 1'b1; mem_err = 1'b1; mem_rdata = 32'h55;
        sample();
        chk1 ("s6_iv", if_valid, 1'b1);
        chk1 ("s6_fault", if_access_fault, 1'b1);
        chk1 ("s6_dv", d_valid, 1'b0);
        next_cycle();
        quiet_inputs();
        sample();
        chk1 ("s6_end_req", mem_req, 1'b0);

        // Randomized phase. The last grant was a fetch, so no data grants
        // have been made against a waiting fetch yet.
        m_out = 1'b0; m_fetch = 1'b0; m_age = 0; m_lat = 0; m_drop = 1'b0;
        m_addr = '0; m_wdata = '0; m_we = 1'b0; m_wstrb = '0; m_passed_over = 0;
        if_pend = 1'b0; if_a = '0; d_pend = 1'b0; d_a = '0; d_wd = '0; d_w = 1'b0; d_s = '0;
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            if (!if_pend && ($urandom_range(0, 2) == 0)) begin
                if_pend = 1'b1; if_a = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_pend && ($urandom_range(0, 2) == 0)) begin
                d_pend = 1'b1; d_a = $urandom; d_wd = $urandom;
                d_w = 1'($urandom_range(0, 1)); d_s = 4'($urandom_range(0, 15));
            end
            if_en = if_pend; if_addr = if_a;
            d_en = d_pend; d_addr = d_a; d_wdata = d_wd; d_we = d_w; d_wstrb = d_s;
            if_flush = ($urandom_range(0, 9) == 0);
            mem_rdata = $urandom;
            mem_err = ($urandom_range(0, 7) == 0);
            if (m_out) mem_rsp_valid = (m_age == m_lat);
            else       mem_rsp_valid = ($urandom_range(0, 7) == 0);
            sample();

            done   = m_out && (mem_rsp_valid || (m_age == int'(TMO)));
            exp_iv = done && m_fetch && !m_drop && !if_flush;
            exp_dv = done && !m_fetch;
            exp_fault = mem_rsp_valid ? mem_err : 1'b1;
            chk1("r_mem_req", mem_req, m_out);
            if (m_out) begin
                chk32("r_mem_addr", mem_addr, m_addr);
                chk1 ("r_mem_we", mem_we, m_we);
                if (!m_fetch) begin
                    chk32("r_mem_wdata", mem_wdata, m_wdata);
                    chk32("r_mem_wstrb", 32'(mem_wstrb), 32'(m_wstrb));
                end
            end
            chk1("r_if_valid", if_valid, exp_iv);
            chk1("r_d_valid", d_valid, exp_dv);
            if (exp_iv) begin
                chk32("r_if_inst", if_inst, mem_rdata);
                chk1 ("r_if_fault", if_access_fault, exp_fault);
            end
            if (exp_dv) begin
                chk32("r_d_rdata", d_rdata, mem_rdata);
                chk1 ("r_d_fault", d_access_fault, exp_fault);
            end

            if (m_out) begin
                if (m_fetch && (exp_iv || (if_flush && !m_drop))) if_pend = 1'b0;
                if (done) begin
                    m_out = 1'b0;
                    if (!m_fetch) d_pend = 1'b0;
                end else begin
                    m_age++;
                    if (m_fetch && if_flush) m_drop = 1'b1;
                end
            end else begin
                fetch_wins = if_en && (!d_en || (m_passed_over == int'(LIMIT)));
                if (fetch_wins || d_en) begin
                    m_out = 1'b1; m_age = 0; m_drop = 1'b0;
                    m_lat = ($urandom_range(0, 39) == 0) ? 100000 : int'($urandom_range(0, 4));
                end
                if (fetch_wins) begin
                    m_fetch = 1'b1; m_addr = if_a; m_we = 1'b0; m_passed_over = 0;
                end else if (d_en) begin
                    m_fetch = 1'b0; m_addr = d_a; m_we = d_w; m_wdata = d_wd; m_wstrb = d_s;
                    if (if_en && (m_passed_over < int'(LIMIT))) m_passed_over++;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive data grants while a fetch request is pending.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: maximum cycles to wait for a memory response before faulting.
REQ-003 clk  in  1  single clock for the block; all state changes on posedge clk.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 if_addr  in  32  fetch address, held stable while if_en is high.
REQ-006 if_en  in  1  fetch request, level, held until if_valid or if_flush.
REQ-007 if_flush  in  1  one-cycle pulse on PC override; cancels the in-flight fetch.
REQ-008 if_inst  out  32  fetched word; valid only with if_valid.
REQ-009 if_valid  out  1  fetch response strobe.
REQ-010 if_access_fault  out  1  fetch fault; qualified by if_valid.
REQ-011 d_addr, d_wdata  in  32 each  data request address and write data.
REQ-012 d_en, d_we  in  1 each  data request (level, held until d_valid) and write select.
REQ-013 d_wstrb  in  4  byte enables for writes.
REQ-014 d_rdata  out  32  load data; d_valid  out  1  response strobe; d_access_fault  out  1  fault, qualified by d_valid.
REQ-015 mem_req  out  1  memory request; mem_addr, mem_wdata  out  32; mem_we  out  1; mem_wstrb  out  4.
REQ-016 mem_rsp_valid  in  1  response strobe; mem_rdata  in  32; mem_err  in  1  bus error.

Function
REQ-017 The FSM SHALL have three states: IDLE, IF_BUSY, D_BUSY.
REQ-018 In IDLE with only d_en high -> D_BUSY; only if_en high -> IF_BUSY; both high -> D_BUSY unless starve_cnt == STARVE_LIMIT, in which case -> IF_BUSY.
REQ-019 starve_cnt (3 bits minimum): increment on each D_BUSY grant made while if_en is high; clear on any IF_BUSY grant; saturate at STARVE_LIMIT.
REQ-020 mem_req and all mem_* request fields SHALL be registered at grant and held constant until the response cycle; mem_req SHALL be 0 in IDLE.
REQ-021 The response cycle is the cycle with mem_rsp_valid high in a BUSY state; the FSM SHALL return to IDLE on the next edge, with at most one transaction outstanding.
REQ-022 Responses SHALL be combinational in the response cycle: if_valid = mem_rsp_valid & IF_BUSY & ~drop; d_valid = mem_rsp_valid & D_BUSY; data from mem_rdata; fault = mem_err.
REQ-023 An if_flush pulse in IF_BUSY SHALL set drop; the matching response is consumed with no if_valid, and drop clears on return to IDLE.
REQ-024 if_flush in IDLE or D_BUSY SHALL have no effect.
REQ-025 if_flush coincident with the IF_BUSY response cycle SHALL suppress if_valid in that cycle.
REQ-026 wait_cnt (8 bits) SHALL clear at grant and increment each BUSY cycle without a response.
REQ-027 When wait_cnt reaches TIMEOUT_CYCLES, the block SHALL, in that cycle, pulse the owner's valid with access_fault=1 (if_valid still masked by drop), drop mem_req, and return to IDLE.
REQ-028 A late mem_rsp_valid arriving in IDLE SHALL be ignored.
REQ-029 A new grant SHALL be made no earlier than the cycle after return to IDLE; peak throughput is one transaction every two cycles.
REQ-030 if_valid and d_valid SHALL never be high in the same cycle.

Reset
REQ-031 While reset is low: state=IDLE; starve_cnt, wait_cnt, and drop = 0; mem_req=0; mem_addr, mem_wdata, mem_wstrb, mem_we = 0.
REQ-032 Reset asserted mid-transaction SHALL abandon that transaction immediately; no valid SHALL be produced for it.
REQ-033 First grant possible on the first posedge after reset deasserts.

Structure
REQ-034 The state enum (IDLE/IF_BUSY/D_BUSY) and the fault-code constants SHALL live in the shared pipeline package.
REQ-035 The block SHALL be a single module with no sub-modules; the grant/priority logic SHALL be a separate always_comb block.

Verification
REQ-036 Scenario 1: if_en with if_addr=0x100, memory responds after 2 cycles with 0x00000013 -> one if_valid with if_inst=0x13, fault=0.
REQ-037 Scenario 2: d_en and if_en held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,IF,D...
REQ-038 Scenario 3: if_flush one cycle after IF grant, response 3 cycles later -> no if_valid; next request granted normally.
REQ-039 Scenario 4: d_en write, d_wstrb=0x3, memory silent -> d_valid with d_access_fault=1 exactly at wait_cnt==255; mem_req low the next cycle.
REQ-040 Scenario 5: reset pulled low during D_BUSY -> mem_req=0 asynchronously; no d_valid; late mem_rsp_valid ignored.
REQ-041 Scenario 6: mem_err=1 on a fetch response -> if_valid=1, if_access_fault=1 in the same cycle.
